// File: rtl/plus_recon.sv
// plus_recon: rebuilds mag = lambda + ((rho*phi) >>> RHO_FRAC), wrapping mod 2^14.
// Ports: side_* phi/rho push into an in-order FIFO; lam_* lambda stream pops it;
//        out_valid/out_ready/mag_out is the 2-stage result stream; rst is async active-low.
//        Build with PLUS_STATUS_EN to add fifo_level and sticky side_ovf outputs.
module plus_recon #(
  parameter int DEPTH    = 8,
  parameter int RHO_FRAC = 7,
  parameter int PHI_W    = 14,
  parameter int RHO_W    = 8,
  parameter int LAMBDA_W = 14,
  parameter int MAG_W    = 14,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                side_valid,
  output logic                side_ready,
  input  logic [PHI_W-1:0]    phi_in,
  input  logic [RHO_W-1:0]    rho_in,
  input  logic                lam_valid,
  output logic                lam_ready,
  input  logic [LAMBDA_W-1:0] lambda_in,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef PLUS_STATUS_EN
  output logic [AW:0]         fifo_level,
  output logic                side_ovf,
`endif
  output logic [MAG_W-1:0]    mag_out
);

  localparam int EW     = PHI_W + RHO_W;
  localparam int PROD_W = RHO_W + PHI_W;

  logic [EW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                pipe_en;

  logic [PHI_W-1:0]    rd_phi;
  logic [RHO_W-1:0]    rd_rho;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_sh;

  logic                s1_valid;
  logic [LAMBDA_W-1:0] s1_lam;
  logic [MAG_W-1:0]    s1_rp;
  logic                s2_valid;
  logic [MAG_W-1:0]    s2_mag;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Held low during reset; a pop never frees a slot for the same cycle.
  assign side_ready = rst & ~full;
  assign pipe_en    = ~s2_valid | out_ready;
  assign lam_ready  = ~empty & pipe_en;

  assign push = side_valid & side_ready;
  assign pop  = lam_valid & lam_ready;

  assign {rd_phi, rd_rho} = mem[rd_ptr];

  // phi is unsigned; the zero msb keeps it positive in the signed product.
  assign prod    = PROD_W'($signed(rd_rho))
                 * PROD_W'($signed({1'b0, rd_phi}));
  assign prod_sh = prod >>> RHO_FRAC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {phi_in, rho_in};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_lam   <= '0;
      s1_rp    <= '0;
      s2_valid <= 1'b0;
      s2_mag   <= '0;
    end else if (pipe_en) begin
      s1_valid <= pop;
      s1_lam   <= lambda_in;
      s1_rp    <= prod_sh[MAG_W-1:0];
      s2_valid <= s1_valid;
      // Wrap, not saturate: exact mod-2^14 inverse of the encoder.
      s2_mag   <= s1_lam + s1_rp;
    end
  end

  assign out_valid = s2_valid;
  assign mag_out   = s2_mag;

`ifdef PLUS_STATUS_EN
  assign fifo_level = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      side_ovf <= 1'b0;
    end else if (side_valid && !side_ready) begin
      side_ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_plus_recon.sv
// tb_plus_recon: directed scoreboard bench for plus_recon.
// Stimulus pushes expected mag values; a negedge monitor pops and compares.
module tb_plus_recon;

  logic        clk;
  logic        rst;
  logic        side_valid;
  logic        side_ready;
  logic [13:0] phi_in;
  logic [7:0]  rho_in;
  logic        lam_valid;
  logic        lam_ready;
  logic [13:0] lambda_in;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] mag_out;
`ifdef PLUS_STATUS_EN
  logic [3:0]  fifo_level;
  logic        side_ovf;
`endif

  int tests;
  int fails;
  logic [13:0] exp_q[$];
  logic        held;
  logic [13:0] held_val;

  plus_recon dut (
    .clk        (clk),
    .rst        (rst),
    .side_valid (side_valid),
    .side_ready (side_ready),
    .phi_in     (phi_in),
    .rho_in     (rho_in),
    .lam_valid  (lam_valid),
    .lam_ready  (lam_ready),
    .lambda_in  (lambda_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef PLUS_STATUS_EN
    .fifo_level (fifo_level),
    .side_ovf   (side_ovf),
`endif
    .mag_out    (mag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: handshake timeout, got 0, required 1", name);
  endtask

  // Called just after a negedge; returns at the negedge after the transfer.
  task automatic push(input logic [13:0] p, input logic [7:0] r);
    int n;
    n = 0;
    side_valid = 1'b1;
    phi_in     = p;
    rho_in     = r;
    #1;
    while (!side_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!side_ready) timeout("push");
    else @(posedge clk);
    @(negedge clk);
    side_valid = 1'b0;
  endtask

  task automatic send_lam(input logic [13:0] l, input logic [13:0] e);
    int n;
    n = 0;
    lam_valid = 1'b1;
    lambda_in = l;
    #1;
    while (!lam_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!lam_ready) timeout("send_lam");
    else begin
      exp_q.push_back(e);
      @(posedge clk);
    end
    @(negedge clk);
    lam_valid = 1'b0;
  endtask

  function automatic logic [13:0] rp_of(input logic [13:0] p,
                                        input logic [7:0] r);
    logic signed [22:0] pr;
    logic signed [22:0] sh;
    pr = $signed({{15{r[7]}}, r}) * $signed({9'b0, p});
    sh = pr >>> 7;
    return sh[13:0];
  endfunction

  // Monitor: samples after all inputs for the coming edge have settled.
  always @(negedge clk) begin
    logic [13:0] e;
    #2;
    if (!rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        tests++;
        if (!out_valid || mag_out !== held_val) begin
          fails++;
          $display("FAIL hold: valid=%b mag=%h, required valid=1 mag=%h",
                   out_valid, mag_out, held_val);
        end
      end
      held = 1'b0;
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_out: got mag=%h, required no output", mag_out);
        end else begin
          e = exp_q.pop_front();
          if (mag_out !== e) begin
            fails++;
            $display("FAIL mag_out: got %h, required %h", mag_out, e);
          end
        end
      end else if (out_valid) begin
        held     = 1'b1;
        held_val = mag_out;
      end
    end
  end

  initial begin
    logic [13:0] m;
    logic [13:0] p;
    logic [7:0]  r;
    tests      = 0;
    fails      = 0;
    held       = 1'b0;
    held_val   = '0;
    rst        = 1'b0;
    side_valid = 1'b0;
    phi_in     = '0;
    rho_in     = '0;
    lam_valid  = 1'b0;
    lambda_in  = '0;
    out_ready  = 1'b1;

    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_mag_out", mag_out, 0);
    check("rst_side_ready", side_ready, 0);
    check("rst_lam_ready", lam_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_side_ready", side_ready, 1);
`ifdef PLUS_STATUS_EN
    check("post_rst_level", fifo_level, 0);
`endif

    // Empty FIFO stalls lambda; a push is not visible to pop the same cycle.
    lam_valid = 1'b1;
    lambda_in = 14'h0100;
    #1;
    check("empty_lam_ready", lam_ready, 0);
    side_valid = 1'b1;
    phi_in     = 14'h0200;
    rho_in     = 8'h40;
    #1;
    check("no_bypass", lam_ready, 0);
    @(posedge clk);
    @(negedge clk);
    side_valid = 1'b0;
    #1;
    check("pop_visible", lam_ready, 1);
    exp_q.push_back(14'h0200);
    @(posedge clk);
    @(negedge clk);
    lam_valid = 1'b0;

    // Negative rho and deliberate wrap.
    push(14'h0100, 8'h80);
    send_lam(14'h0000, 14'h3F00);
    push(14'h0200, 8'h40);
    send_lam(14'h1F00, 14'h2000);

    // Fill to full with no lambda, then one more push attempt.
    for (int i = 0; i < 8; i++) begin
      push(14'(i * 256), 8'h40);
    end
    #1;
    check("full_side_ready", side_ready, 0);
    side_valid = 1'b1;
    phi_in     = 14'h3FFF;
    rho_in     = 8'h7F;
    @(posedge clk);
    @(negedge clk);
    side_valid = 1'b0;
    #1;
    check("full_hold_ready", side_ready, 0);
`ifdef PLUS_STATUS_EN
    check("ovf_set", side_ovf, 1);
    check("full_level", fifo_level, 8);
`endif
    for (int i = 0; i < 8; i++) begin
      send_lam(14'(i), 14'(i * 128 + i));
    end

    // Back-to-back stream with a 3-cycle out_ready stall mid-stream.
    for (int i = 0; i < 4; i++) begin
      push(14'h0400, 8'h20);
    end
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          send_lam(14'(i * 16), 14'(256 + i * 16));
        end
      end
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join

    // Round trip through an encoder model.
    for (int i = 0; i < 12; i++) begin
      m = 14'($urandom);
      p = 14'($urandom);
      r = 8'($urandom);
      push(p, r);
      send_lam(m - rp_of(p, r), m);
    end

    repeat (8) @(negedge clk);
    check("drained", exp_q.size(), 0);

    // Async reset mid-stream, with in-flight data and stale side info.
    out_ready = 1'b0;
    push(14'h0200, 8'h40);
    push(14'h3FFF, 8'h7F);
    send_lam(14'h0100, 14'h0200);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_mag_out", mag_out, 0);
    check("arst_side_ready", side_ready, 0);
    check("arst_lam_ready", lam_ready, 0);
    exp_q.delete();
    @(negedge clk);
    #3;
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rel_side_ready", side_ready, 1);
`ifdef PLUS_STATUS_EN
    check("rel_ovf_clear", side_ovf, 0);
    check("rel_level", fifo_level, 0);
`endif
    lam_valid = 1'b1;
    #1;
    check("rel_empty", lam_ready, 0);
    lam_valid = 1'b0;
    push(14'h0100, 8'h40);
    send_lam(14'h0005, 14'h0085);

    repeat (8) @(negedge clk);
    check("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
